flood_port_lookup: RTL
======================

Name: flood_port_lookup

Overview:
Pipeline stage directly downstream of the input arbiter. It accepts the arbiter's serialized packet stream (module-header words, then data words) and rewrites the destination-port field of the IOQ header with a one-hot flood mask: every MAC output queue except the source MAC port. All other words pass through unchanged. Packets with an invalid source port are dropped. Per-packet forwarded and dropped counters are exported.

Parameters:
DATA_WIDTH, 64, datapath width in bits
CTRL_WIDTH, DATA_WIDTH/8, ctrl width in bits
IOQ_CTRL, 8'hFF, ctrl value that identifies the IOQ module-header word
NUM_OUTPUT_QUEUES, 8, width of the destination one-hot field in use; MAC queues are the even indices
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
in_data  in  DATA_WIDTH  word from the upstream arbiter
in_ctrl  in  CTRL_WIDTH  ctrl of in_data
in_wr  in  1  in_data/in_ctrl valid this cycle
in_rdy  out  1  upstream may write; equals !nearly_full of the internal FIFO
out_data  out  DATA_WIDTH  registered output word
out_ctrl  out  CTRL_WIDTH  registered output ctrl
out_wr  out  1  out_data/out_ctrl valid this cycle
out_rdy  in  1  downstream can accept a word
pkt_fwd_cnt  out  CNT_WIDTH  packets forwarded
pkt_drop_cnt  out  CNT_WIDTH  packets dropped

Behaviour:
- Input FIFO: 4 entries, DATA_WIDTH+CTRL_WIDTH bits wide, first-word-fall-through. nearly_full asserts at 3 entries. A write when full is an upstream protocol error and is ignored. The FIFO is cleared on reset.
- IOQ header field map: [15:0] word length, [31:16] source port, [47:32] byte length, [63:48] destination one-hot mask.
- Flood mask computation (combinational, from the FIFO head):
  - src = head_data[31:16].
  - Valid when src < NUM_OUTPUT_QUEUES and src is even.
  - mask = 16'h0055 with bit src cleared; bits at or above NUM_OUTPUT_QUEUES are zero.
- State machine: states MOD_HDRS, IN_PKT, DROP_PKT. Reset state is MOD_HDRS.
- MOD_HDRS, when the FIFO is not empty and out_rdy is high:
  - Header with ctrl == IOQ_CTRL and a valid src: pop the word and emit it with [63:48] replaced by the mask. Stay in MOD_HDRS.
  - Header with ctrl == IOQ_CTRL and an invalid src: pop without writing; go to DROP_PKT.
  - Any other non-zero ctrl (other module header): pop and pass through unchanged.
  - ctrl == 0 (first data word): pop and pass through; go to IN_PKT.
- IN_PKT, when the FIFO is not empty and out_rdy is high: pop and pass through.
  - Non-zero ctrl marks EOP. On EOP, go to MOD_HDRS and increment pkt_fwd_cnt.
- DROP_PKT: pop one word per cycle when the FIFO is not empty; out_rdy is ignored and nothing is written.
  - Track the previous ctrl. A non-zero ctrl after a zero ctrl is EOP: go to MOD_HDRS and increment pkt_drop_cnt.
- Output handshake and latency:
  - One registered stage: out_wr asserts the cycle after the pop.
  - No pop occurs while out_rdy is low, except in DROP_PKT. out_rdy low does not stall an in-flight registered word.
  - Downstream tolerates one word after deasserting out_rdy.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- Reset values: out_wr=0, out_data=0, out_ctrl=0, both counters 0, state MOD_HDRS.
- Reset mid-packet: the partial packet is lost with no counter update. The next packet must begin with headers.
- Simultaneous upstream write and pop in the same cycle is supported; occupancy is unchanged.
- The IOQ header is matched in any position within the header run, not only the first word.

Test Plan:
- Single forward: IOQ header src=2, then 3 data words, last ctrl=8'h80 -> header emitted with [63:48]=16'h0051, other fields unchanged; 4 out_wr pulses starting 1 cycle after the first pop; pkt_fwd_cnt=1.
- Source 0 and 6: separate packets -> masks 16'h0054 and 16'h0015.
- Invalid source: src=3, 5-word packet -> no out_wr for any word; pkt_drop_cnt=1. A following src=4 packet is forwarded with mask 16'h0045.
- Backpressure: out_rdy toggles low every other cycle during a 10-word packet -> output sequence identical and in order, no duplicates or losses; in_rdy deasserts once the FIFO holds 3 entries.
- Back-to-back: two packets with no idle between them -> second header modified correctly; pkt_fwd_cnt=2; state returns to MOD_HDRS.
- Async reset: drive reset low mid-packet, between clock edges -> out_wr=0 and counters 0 immediately. After release, a new packet src=0 is forwarded with mask 16'h0054.

Source files
------------

// File: rtl/flood_port_lookup.sv
// flood_port_lookup: rewrites the IOQ header destination field with a flood
// mask covering every MAC queue except the source port, drops packets whose
// source port is not a valid MAC port, and counts forwarded/dropped packets.
module flood_port_lookup #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(8'hFF),
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [CNT_WIDTH-1:0]  pkt_fwd_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_drop_cnt
);

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned FILL_W     = 3;
    localparam logic [15:0] MAC_QUEUES = 16'h0055;
    localparam logic [15:0] QUEUE_MASK = (NUM_OUTPUT_QUEUES >= 16) ? 16'hFFFF :
                                         16'((32'd1 << NUM_OUTPUT_QUEUES) - 32'd1);

    typedef enum logic [1:0] {
        MOD_HDRS = 2'd0,
        IN_PKT   = 2'd1,
        DROP_PKT = 2'd2
    } state_e;

    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [CTRL_WIDTH-1:0] mem_ctrl_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [FILL_W-1:0]     fill_q;

    logic                  fifo_empty_c;
    logic                  fifo_full_c;
    logic                  wr_en_c;
    logic                  pop_c;
    logic [DATA_WIDTH-1:0] head_data_c;
    logic [CTRL_WIDTH-1:0] head_ctrl_c;

    // FSM and output registers
    state_e                state_q, state_d;
    logic                  prev_zero_q;
    logic                  out_wr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic [CNT_WIDTH-1:0]  fwd_cnt_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;

    logic                  emit_c;
    logic [DATA_WIDTH-1:0] emit_data_c;
    logic                  fwd_inc_c;
    logic                  drop_inc_c;

    logic [15:0]           src_c;
    logic                  src_valid_c;
    logic [15:0]           mask_c;
    logic [DATA_WIDTH-1:0] hdr_mod_c;
    logic                  is_ioq_c;
    logic                  is_data_c;

    assign fifo_empty_c = (fill_q == '0);
    assign fifo_full_c  = (fill_q == FILL_W'(FIFO_DEPTH));
    assign wr_en_c      = in_wr && !fifo_full_c;
    assign head_data_c  = mem_data_q[rd_ptr_q];
    assign head_ctrl_c  = mem_ctrl_q[rd_ptr_q];
    assign in_rdy       = (fill_q < FILL_W'(3));

    // 4-entry first-word-fall-through input FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_ctrl_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_en_c) begin
                mem_data_q[wr_ptr_q] <= in_data;
                mem_ctrl_q[wr_ptr_q] <= in_ctrl;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en_c && !pop_c) begin
                fill_q <= fill_q + FILL_W'(1);
            end else if (!wr_en_c && pop_c) begin
                fill_q <= fill_q - FILL_W'(1);
            end
        end
    end

    // Flood mask from the FIFO head: MAC queues minus the source port
    always_comb begin
        src_c       = head_data_c[31:16];
        src_valid_c = (32'(src_c) < NUM_OUTPUT_QUEUES) && !src_c[0];
        mask_c      = MAC_QUEUES & QUEUE_MASK & ~(16'd1 << src_c);
        hdr_mod_c   = head_data_c;
        hdr_mod_c[63:48] = mask_c;
        is_ioq_c    = (head_ctrl_c == IOQ_CTRL);
        is_data_c   = (head_ctrl_c == '0);
    end

    // Next-state, pop and emit decisions
    always_comb begin
        state_d     = state_q;
        pop_c       = 1'b0;
        emit_c      = 1'b0;
        emit_data_c = head_data_c;
        fwd_inc_c   = 1'b0;
        drop_inc_c  = 1'b0;
        case (state_q)
            MOD_HDRS: begin
                if (!fifo_empty_c && out_rdy) begin
                    pop_c = 1'b1;
                    if (is_ioq_c) begin
                        if (src_valid_c) begin
                            emit_c      = 1'b1;
                            emit_data_c = hdr_mod_c;
                        end else begin
                            state_d = DROP_PKT;
                        end
                    end else if (is_data_c) begin
                        emit_c  = 1'b1;
                        state_d = IN_PKT;
                    end else begin
                        emit_c = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (!fifo_empty_c && out_rdy) begin
                    pop_c  = 1'b1;
                    emit_c = 1'b1;
                    if (!is_data_c) begin
                        state_d   = MOD_HDRS;
                        fwd_inc_c = 1'b1;
                    end
                end
            end
            DROP_PKT: begin
                if (!fifo_empty_c) begin
                    pop_c = 1'b1;
                    if (!is_data_c && prev_zero_q) begin
                        state_d    = MOD_HDRS;
                        drop_inc_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = MOD_HDRS;
            end
        endcase
    end

    // State, output stage and statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MOD_HDRS;
            prev_zero_q <= 1'b0;
            out_wr_q    <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            fwd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_wr_q <= emit_c;
            if (pop_c) begin
                prev_zero_q <= is_data_c;
            end
            if (emit_c) begin
                out_data_q <= emit_data_c;
                out_ctrl_q <= head_ctrl_c;
            end
            if (fwd_inc_c) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_WIDTH'(1);
            end
            if (drop_inc_c) begin
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign out_wr       = out_wr_q;
    assign out_data     = out_data_q;
    assign out_ctrl     = out_ctrl_q;
    assign pkt_fwd_cnt  = fwd_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;

endmodule
